nios2_debug_mem_arbiter: RTL and testbench

//  Shares the CPU's single-port on-chip debug RAM (OCI mem) between two requesters:
//  - JTAG-side command strobes from the debug-slave sysclk stage (take_action_*/jdo).
//  - The Avalon debug_mem_slave used by the CPU's debug monitor.

---
 rtl/nios2_dbg_pkg.sv | 28 ++
 rtl/nios2_dbg_jtag_cmd_capture.sv | 99 +++++++++
 rtl/nios2_debug_mem_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_nios2_debug_mem_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios2_dbg_pkg.sv
// Shared definitions for the Nios II debug-memory arbiter.
//  - JTAG jdo field offsets (address load, write data, read-request flag)
//  - Arbiter FSM state encoding
//  - Encoding of the single pending JTAG command
package nios2_dbg_pkg;

    localparam int JDO_W     = 38;
    localparam int ADDR_LSB  = 17;
    localparam int WDATA_LSB = 3;
    localparam int RD_FLAG   = 35;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_JT_ACC = 3'd1,
        ST_JT_RD  = 3'd2,
        ST_AV_ACC = 3'd3,
        ST_AV_RD  = 3'd4
    } state_t;

    // A read issued by an address load leaves the address alone;
    // a no-action read advances it afterwards.
    typedef enum logic [1:0] {
        CMD_RD_NOINC = 2'd0,
        CMD_WR       = 2'd1,
        CMD_RD_INC   = 2'd2
    } jcmd_t;

endpackage

// File: rtl/nios2_dbg_jtag_cmd_capture.sv
// JTAG command capture for the debug-memory arbiter.
//  Resolves simultaneous strobes (ocimem_a > ocimem_b > no_action), holds
//  one pending command and raises a sticky overrun flag for dropped strobes.
// Ports:
//  i_clk, i_reset_n   clock, synchronous active-low reset
//  i_jdo              JTAG data-out register
//  i_take_a/b/no      command strobes
//  i_retire           arbiter has finished the pending command this cycle
//  o_load/o_load_addr address-load request for the arbiter's address register
//  o_pending/o_cmd    pending command flag and kind
//  o_wdata            write data of a pending write
//  o_overrun          sticky dropped-strobe flag
module nios2_dbg_jtag_cmd_capture
    import nios2_dbg_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [JDO_W-1:0]  i_jdo,
    input  logic              i_take_a,
    input  logic              i_take_b,
    input  logic              i_take_no,
    input  logic              i_retire,
    output logic              o_load,
    output logic [ADDR_W-1:0] o_load_addr,
    output logic              o_pending,
    output logic [1:0]        o_cmd,
    output logic [DATA_W-1:0] o_wdata,
    output logic              o_overrun
);

    logic              r_pending;
    logic [1:0]        r_cmd;
    logic [DATA_W-1:0] r_wdata;
    logic              r_overrun;

    logic       w_slot_free;
    logic       w_any;
    logic       w_multi;
    logic       w_accept;
    logic       w_queue;
    logic [1:0] w_cmd_next;
    logic       w_unused_jdo;

    // The slot is also free in the cycle the arbiter retires the current
    // command, so a host streaming commands back to back keeps the RAM busy.
    assign w_slot_free = ~r_pending | i_retire;
    assign w_any       = i_take_a | i_take_b | i_take_no;
    assign w_multi     = (i_take_a & i_take_b) | (i_take_a & i_take_no) | (i_take_b & i_take_no);
    assign w_accept    = w_any & w_slot_free;

    // An address load without the read flag is finished by the load itself.
    assign w_queue     = w_accept & ~(i_take_a & ~i_jdo[RD_FLAG]);

    assign o_load      = i_take_a & w_slot_free;
    assign o_load_addr = i_jdo[ADDR_LSB +: ADDR_W];

    always_comb begin
        w_cmd_next = CMD_RD_INC;
        if (i_take_a) begin
            w_cmd_next = CMD_RD_NOINC;
        end else if (i_take_b) begin
            w_cmd_next = CMD_WR;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_pending <= 1'b0;
            r_cmd     <= CMD_RD_INC;
            r_wdata   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_queue) begin
                r_pending <= 1'b1;
                r_cmd     <= w_cmd_next;
            end else if (i_retire) begin
                r_pending <= 1'b0;
            end
            if (w_accept && !i_take_a && i_take_b) begin
                r_wdata <= i_jdo[WDATA_LSB +: DATA_W];
            end
            if (w_multi || (w_any && !w_slot_free)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign o_pending = r_pending;
    assign o_cmd     = r_cmd;
    assign o_wdata   = r_wdata;
    assign o_overrun = r_overrun;

    // jdo bits outside the command field map carry nothing for this block.
    assign w_unused_jdo = ^{i_jdo[JDO_W-1:RD_FLAG+1], i_jdo[WDATA_LSB-1:0]};

endmodule

// File: rtl/nios2_debug_mem_arbiter.sv
// Nios II debug-memory arbiter.
//  Shares the single-port OCI debug RAM between JTAG commands (address load,
//  write-with-increment, read-with-increment) and the Avalon debug_mem_slave.
//  JTAG wins unless it has been granted STARVE_MAX times in a row while an
//  Avalon request waits.
// Ports:
//  i_clk, i_reset_n                         clock, synchronous active-low reset
//  i_jdo, i_take_action_ocimem_a/b,
//  i_take_no_action_ocimem_a                JTAG command interface
//  i_av_address/read/write/writedata/
//  byteenable, o_av_waitrequest/readdata    Avalon slave
//  o_ram_en/we/addr/wdata/be, i_ram_rdata   OCI RAM port (1-cycle read latency)
//  o_mondreg                                last JTAG read data
//  o_monitor_ready                          no JTAG command pending
//  o_jtag_overrun                           sticky dropped-strobe flag
module nios2_debug_mem_arbiter
    import nios2_dbg_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [JDO_W-1:0]  i_jdo,
    input  logic              i_take_action_ocimem_a,
    input  logic              i_take_action_ocimem_b,
    input  logic              i_take_no_action_ocimem_a,
    input  logic [ADDR_W-1:0] i_av_address,
    input  logic              i_av_read,
    input  logic              i_av_write,
    input  logic [DATA_W-1:0] i_av_writedata,
    input  logic [3:0]        i_av_byteenable,
    output logic              o_av_waitrequest,
    output logic [DATA_W-1:0] o_av_readdata,
    output logic              o_ram_en,
    output logic              o_ram_we,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_wdata,
    output logic [3:0]        o_ram_be,
    input  logic [DATA_W-1:0] i_ram_rdata,
    output logic [DATA_W-1:0] o_mondreg,
    output logic              o_monitor_ready,
    output logic              o_jtag_overrun
);

    localparam int              SC_W       = $clog2(STARVE_MAX + 1);
    localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_addr;
    logic [SC_W-1:0]   r_starve_cnt;
    logic [DATA_W-1:0] r_mondreg;
    logic [DATA_W-1:0] r_av_readdata;

    logic              w_load;
    logic [ADDR_W-1:0] w_load_addr;
    logic              w_pending;
    logic [1:0]        w_pend_cmd;
    logic [DATA_W-1:0] w_pend_wdata;
    logic              w_retire;
    logic              w_av_req;
    logic              w_jt_write;
    logic              w_addr_inc;

    nios2_dbg_jtag_cmd_capture #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_capture (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_jdo       (i_jdo),
        .i_take_a    (i_take_action_ocimem_a),
        .i_take_b    (i_take_action_ocimem_b),
        .i_take_no   (i_take_no_action_ocimem_a),
        .i_retire    (w_retire),
        .o_load      (w_load),
        .o_load_addr (w_load_addr),
        .o_pending   (w_pending),
        .o_cmd       (w_pend_cmd),
        .o_wdata     (w_pend_wdata),
        .o_overrun   (o_jtag_overrun)
    );

    assign w_av_req   = i_av_read | i_av_write;
    assign w_jt_write = (w_pend_cmd == CMD_WR);

    // Writes finish in the access cycle, reads after the data cycle.
    assign w_retire   = ((r_state == ST_JT_ACC) && w_jt_write) || (r_state == ST_JT_RD);
    assign w_addr_inc = ((r_state == ST_JT_ACC) && w_jt_write) ||
                        ((r_state == ST_JT_RD) && (w_pend_cmd == CMD_RD_INC));

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_pending && ((r_starve_cnt < STARVE_LIM) || !w_av_req)) begin
                    w_state_next = ST_JT_ACC;
                end else if (w_av_req) begin
                    w_state_next = ST_AV_ACC;
                end
            end
            ST_JT_ACC: w_state_next = w_jt_write ? ST_IDLE : ST_JT_RD;
            ST_JT_RD:  w_state_next = ST_IDLE;
            ST_AV_ACC: w_state_next = i_av_write ? ST_IDLE : ST_AV_RD;
            ST_AV_RD:  w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        o_ram_en         = 1'b0;
        o_ram_we         = 1'b0;
        o_ram_addr       = r_addr;
        o_ram_wdata      = w_pend_wdata;
        o_ram_be         = 4'hF;
        o_av_waitrequest = 1'b1;
        unique case (r_state)
            ST_JT_ACC: begin
                o_ram_en = 1'b1;
                o_ram_we = w_jt_write;
            end
            ST_AV_ACC: begin
                o_ram_en         = 1'b1;
                o_ram_we         = i_av_write;
                o_ram_addr       = i_av_address;
                o_ram_wdata      = i_av_writedata;
                o_ram_be         = i_av_byteenable;
                o_av_waitrequest = ~i_av_write;
            end
            ST_AV_RD: begin
                o_av_waitrequest = 1'b0;
            end
            default: begin
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_addr        <= '0;
            r_starve_cnt  <= '0;
            r_mondreg     <= '0;
            r_av_readdata <= '0;
        end else begin
            // A load can coincide with the retiring command; the newer command wins.
            if (w_load) begin
                r_addr <= w_load_addr;
            end else if (w_addr_inc) begin
                r_addr <= r_addr + 1'b1;
            end

            if ((r_state == ST_IDLE) && (w_state_next == ST_JT_ACC)) begin
                if (r_starve_cnt < STARVE_LIM) begin
                    r_starve_cnt <= r_starve_cnt + 1'b1;
                end
            end else if (r_state == ST_AV_ACC) begin
                r_starve_cnt <= '0;
            end

            if (r_state == ST_JT_RD) begin
                r_mondreg <= i_ram_rdata;
            end
            if (r_state == ST_AV_RD) begin
                r_av_readdata <= i_ram_rdata;
            end
        end
    end

    // Read data is passed straight through in the cycle waitrequest drops and
    // held afterwards.
    assign o_av_readdata   = (r_state == ST_AV_RD) ? i_ram_rdata : r_av_readdata;
    assign o_mondreg       = r_mondreg;
    assign o_monitor_ready = ~w_pending;

endmodule

// File: tb/tb_nios2_debug_mem_arbiter.sv
module tb_nios2_debug_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_a, take_b, take_no;
    logic [7:0]  av_address;
    logic        av_read, av_write;
    logic [31:0] av_writedata;
    logic [3:0]  av_byteenable;
    logic        o_av_waitrequest;
    logic [31:0] o_av_readdata;
    logic        o_ram_en, o_ram_we;
    logic [7:0]  o_ram_addr;
    logic [31:0] o_ram_wdata;
    logic [3:0]  o_ram_be;
    logic [31:0] ram_rdata;
    logic [31:0] o_mondreg;
    logic        o_monitor_ready, o_jtag_overrun;

    always #5 clk = ~clk;

    nios2_debug_mem_arbiter dut (
        .i_clk                     (clk),
        .i_reset_n                 (reset_n),
        .i_jdo                     (jdo),
        .i_take_action_ocimem_a    (take_a),
        .i_take_action_ocimem_b    (take_b),
        .i_take_no_action_ocimem_a (take_no),
        .i_av_address              (av_address),
        .i_av_read                 (av_read),
        .i_av_write                (av_write),
        .i_av_writedata            (av_writedata),
        .i_av_byteenable           (av_byteenable),
        .o_av_waitrequest          (o_av_waitrequest),
        .o_av_readdata             (o_av_readdata),
        .o_ram_en                  (o_ram_en),
        .o_ram_we                  (o_ram_we),
        .o_ram_addr                (o_ram_addr),
        .o_ram_wdata               (o_ram_wdata),
        .o_ram_be                  (o_ram_be),
        .i_ram_rdata               (ram_rdata),
        .o_mondreg                 (o_mondreg),
        .o_monitor_ready           (o_monitor_ready),
        .o_jtag_overrun            (o_jtag_overrun)
    );

    // ---------------- model state ----------------
    typedef struct packed {
        logic [7:0]  addr;
        logic [3:0]  be;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_wr[$];
    logic [31:0] ref_mem [256];
    logic [31:0] mem [256];
    logic [7:0]  model_addr;
    logic [31:0] exp_mondreg;
    logic        exp_overrun;
    int          total = 0;
    int          bad   = 0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bench RAM: one-cycle read latency, read-before-write.
    always @(posedge clk) begin
        if (o_ram_en) begin
            if (o_ram_we) mem[o_ram_addr] <= merge(mem[o_ram_addr], o_ram_wdata, o_ram_be);
            ram_rdata <= mem[o_ram_addr];
        end
    end

    // Compare process: every RAM write must be the next one the model expects,
    // every completed Avalon read must return the model's memory word, and the
    // overrun flag must follow the model.
    always @(negedge clk) begin
        if (reset_n) begin
            if (o_ram_en && o_ram_we) begin
                if (exp_wr.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL ram_write: unexpected write addr=%h data=%h", o_ram_addr, o_ram_wdata);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    chk("ram_write", 64'({o_ram_addr, o_ram_be, o_ram_wdata}), 64'(e));
                end
            end
            if (av_read && !o_av_waitrequest)
                chk("av_readdata", 64'(o_av_readdata), 64'(ref_mem[av_address]));
            chk("overrun", 64'(o_jtag_overrun), 64'(exp_overrun));
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic jt_load(input logic [7:0] a, input logic rd);
        jdo = '0;
        jdo[24:17] = a;
        jdo[35] = rd;
        take_a = 1'b1;
        step();
        take_a = 1'b0;
        model_addr = a;
        if (rd) exp_mondreg = ref_mem[a];
        $display("txn jtag load addr=%h rd=%0d", a, rd);
    endtask

    task automatic jt_write(input logic [31:0] d);
        jdo = '0;
        jdo[34:3] = d;
        take_b = 1'b1;
        exp_wr.push_back({model_addr, 4'hF, d});
        ref_mem[model_addr] = d;
        $display("txn jtag write addr=%h data=%h", model_addr, d);
        model_addr = model_addr + 8'd1;
        step();
        take_b = 1'b0;
    endtask

    task automatic jt_read_inc();
        take_no = 1'b1;
        step();
        take_no = 1'b0;
        exp_mondreg = ref_mem[model_addr];
        $display("txn jtag read addr=%h", model_addr);
        model_addr = model_addr + 8'd1;
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!o_monitor_ready && n < 20) begin
            step();
            n++;
        end
        chk({name, "_ready"}, 64'(o_monitor_ready), 64'(1));
    endtask

    // Avalon access; lat counts cycles from the request to the cycle in which
    // waitrequest is low (the request cycle itself is 0).
    task automatic av_access(input logic wr, input logic [7:0] a, input logic [31:0] d,
                             input logic [3:0] be, output int lat, output logic [31:0] rd);
        av_address    = a;
        av_writedata  = d;
        av_byteenable = be;
        av_read       = ~wr;
        av_write      = wr;
        if (wr) begin
            exp_wr.push_back({a, be, d});
            ref_mem[a] = merge(ref_mem[a], d, be);
        end
        lat = 0;
        @(negedge clk);
        while (o_av_waitrequest && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("av_done", 64'(o_av_waitrequest), 64'(0));
        rd = o_av_readdata;
        $display("txn avalon %s addr=%h data=%h lat=%0d", wr ? "write" : "read", a, wr ? d : rd, lat);
        step();
        av_read  = 1'b0;
        av_write = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        int          lat;
        int          jw;
        logic [31:0] d;

        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        reset_n = 1'b0;
        jdo = '0;
        take_a = 1'b0; take_b = 1'b0; take_no = 1'b0;
        av_address = '0; av_read = 1'b0; av_write = 1'b0;
        av_writedata = '0; av_byteenable = '0;
        model_addr = '0; exp_mondreg = '0; exp_overrun = 1'b0;

        // Reset state
        step(); step(); step();
        chk("rst_waitreq", 64'(o_av_waitrequest), 64'(1));
        chk("rst_ram_en", 64'(o_ram_en), 64'(0));
        chk("rst_ram_we", 64'(o_ram_we), 64'(0));
        chk("rst_mondreg", 64'(o_mondreg), 64'(0));
        chk("rst_readdata", 64'(o_av_readdata), 64'(0));
        chk("rst_ready", 64'(o_monitor_ready), 64'(1));
        chk("rst_overrun", 64'(o_jtag_overrun), 64'(0));
        reset_n = 1'b1;
        step();

        // Address load without read: no RAM access, nothing pending
        jt_load(8'h10, 1'b0);
        chk("load_ready", 64'(o_monitor_ready), 64'(1));
        chk("load_no_ram", 64'(o_ram_en), 64'(0));

        // Write lands 2 clk after the strobe
        jt_write(32'hDEADBEEF);
        chk("wr_lat1_idle", 64'(o_ram_en), 64'(0));
        step();
        chk("wr_lat2_access", 64'({o_ram_en, o_ram_we, o_ram_addr}), 64'({1'b1, 1'b1, 8'h10}));
        wait_ready("wr1");
        chk("mem_10", 64'(mem[8'h10]), 64'(32'hDEADBEEF));

        // Load with read: MonDReg valid 3 clk after the strobe, address unchanged
        jt_load(8'h10, 1'b1);
        step(); step();
        chk("rd_lat_early", 64'(o_mondreg), 64'(0));
        step();
        chk("rd_lat_3clk", 64'(o_mondreg), 64'(32'hDEADBEEF));
        wait_ready("rd1");

        // no_action reads at 0x10 again, then advances to 0x11
        jt_read_inc();
        wait_ready("rd2");
        chk("mondreg_noact", 64'(o_mondreg), 64'(exp_mondreg));
        jt_write(32'hCAFE0011);
        wait_ready("wr2");
        chk("mem_11", 64'(mem[8'h11]), 64'(32'hCAFE0011));
        jt_load(8'h11, 1'b1);
        wait_ready("rd3");
        chk("mondreg_11", 64'(o_mondreg), 64'(32'hCAFE0011));
        chk("mondreg_model", 64'(o_mondreg), 64'(exp_mondreg));

        // Avalon write / byte-enabled write / read with latencies
        av_access(1'b1, 8'h40, 32'h12345678, 4'hF, lat, d);
        chk("av_wr_lat", 64'(lat), 64'(1));
        av_access(1'b1, 8'h40, 32'hAABBCCDD, 4'b0101, lat, d);
        av_access(1'b0, 8'h40, 32'h0, 4'h0, lat, d);
        chk("av_rd_lat", 64'(lat), 64'(2));
        chk("av_rd_data", 64'(d), 64'(32'h12BB56DD));

        // Starvation: streaming JTAG writes vs a held Avalon read
        jw = 0;
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    jt_write(32'h50000000 + 32'(i));
                    step();
                end
            end
            begin
                step();
                av_access(1'b0, 8'h40, 32'h0, 4'h0, lat, d);
            end
            begin
                for (int k = 0; k < 40; k++) begin
                    @(negedge clk);
                    if (o_ram_en && !o_ram_we) break;
                    if (o_ram_en && o_ram_we) jw++;
                end
            end
        join
        chk("starve_grants", 64'(jw), 64'(4));
        chk("starve_av_data", 64'(d), 64'(32'h12BB56DD));
        wait_ready("starve");
        step(); step();

        // Simultaneous ocimem_a and ocimem_b: only the load executes
        jdo = '0;
        jdo[34:3] = 32'hBAD0BAD0;
        jdo[24:17] = 8'h20;
        jdo[35] = 1'b0;
        take_a = 1'b1;
        take_b = 1'b1;
        step();
        take_a = 1'b0;
        take_b = 1'b0;
        model_addr = 8'h20;
        exp_overrun = 1'b1;
        $display("txn jtag load+write collision addr=20");
        chk("collide_overrun", 64'(o_jtag_overrun), 64'(1));
        chk("collide_ready", 64'(o_monitor_ready), 64'(1));
        step(); step(); step();
        jt_write(32'h20202020);
        wait_ready("collide");
        chk("mem_20", 64'(mem[8'h20]), 64'(32'h20202020));

        // Address wrap at 0xFF
        jt_load(8'hFF, 1'b0);
        jt_write(32'h12345678);
        wait_ready("wrap1");
        jt_write(32'h87654321);
        wait_ready("wrap2");
        chk("mem_ff", 64'(mem[8'hFF]), 64'(32'h12345678));
        chk("mem_00", 64'(mem[8'h00]), 64'(32'h87654321));

        // Reset in the middle of an Avalon read
        av_address = 8'h40;
        av_read = 1'b1;
        step();
        chk("mid_av_acc", 64'({o_av_waitrequest, o_ram_en}), 64'({1'b1, 1'b1}));
        step();
        chk("mid_av_rd", 64'(o_av_waitrequest), 64'(0));
        reset_n = 1'b0;
        av_read = 1'b0;
        step();
        reset_n = 1'b1;
        model_addr = 8'h00;
        exp_overrun = 1'b0;
        $display("txn reset during avalon read");
        chk("mid_rst_waitreq", 64'(o_av_waitrequest), 64'(1));
        chk("mid_rst_ram_en", 64'(o_ram_en), 64'(0));
        chk("mid_rst_mondreg", 64'(o_mondreg), 64'(0));
        chk("mid_rst_readdata", 64'(o_av_readdata), 64'(0));
        chk("mid_rst_overrun", 64'(o_jtag_overrun), 64'(0));
        step();

        // JTAG address restarts at 0 after reset
        jt_write(32'h5A5A5A5A);
        wait_ready("post_rst");
        chk("mem_00_post_rst", 64'(mem[8'h00]), 64'(32'h5A5A5A5A));
        step(); step();
        chk("writes_drained", 64'(exp_wr.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
